// File: rtl/ysyx_24110006_pkg.sv
// rtl/ysyx_24110006_pkg.sv - shared opcodes, fetch FSM states and bus constants for the IFU
package ysyx_24110006_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [1:0]  RESP_OKAY        = 2'b00;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_DONE = 3'd3,
    ST_WAIT = 3'd4,
    ST_HALT = 3'd5
  } ifu_state_e;

endpackage

// File: rtl/ysyx_24110006_immgen.sv
// rtl/ysyx_24110006_immgen.sv - combinational sign-extended immediate generator
module ysyx_24110006_immgen
  import ysyx_24110006_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic [31:0] o_imm
);

  logic [6:0] w_opcode;

  assign w_opcode = i_inst[6:0];

  // R-type carries funct7 so decode can tell mul/sub variants apart via the immediate path.
  always_comb begin
    o_imm = 32'h0;
    case (w_opcode)
      OP_IMM, OP_JALR, OP_LOAD, OP_SYSTEM:
        o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      OP_LUI, OP_AUIPC:
        o_imm = {i_inst[31:12], 12'b0};
      OP_JAL:
        o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      OP_STORE:
        o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      OP_BRANCH:
        o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      OP_REG:
        o_imm = {25'b0, i_inst[31:25]};
      default:
        o_imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/ysyx_24110006_ifu.sv
// rtl/ysyx_24110006_ifu.sv - multi-cycle instruction fetch unit (PC, AXI-lite read, immgen)
// Optional performance counters enabled by defining YSYX_IFU_PERF_EN.
module ysyx_24110006_ifu
  import ysyx_24110006_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pc_valid,
  input  logic [31:0] i_dnpc,
  output logic [31:0] o_pc,
  output logic        o_mem_arvalid,
  output logic [31:0] o_mem_araddr,
  input  logic        i_mem_arready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  input  logic [1:0]  i_mem_rresp,
  output logic        o_mem_rready,
  output logic [31:0] o_inst,
  output logic [31:0] o_imm,
  output logic        o_valid,
  output logic        o_fault,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
);

  ifu_state_e  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_imm;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_valid;
  logic        r_fault;
  logic [31:0] w_imm;

  ysyx_24110006_immgen u_immgen (
    .i_inst (i_mem_rdata),
    .o_imm  (w_imm)
  );

  // Handshake flags are set on entry to their state so they track the state register exactly.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_inst    <= 32'h0;
      r_imm     <= 32'h0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state   <= ST_AR;
          r_arvalid <= 1'b1;
        end
        ST_AR: begin
          if (i_mem_arready) begin
            r_state   <= ST_R;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        ST_R: begin
          if (i_mem_rvalid) begin
            r_rready <= 1'b0;
            if (i_mem_rresp == RESP_OKAY) begin
              r_inst  <= i_mem_rdata;
              r_imm   <= w_imm;
              r_valid <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_fault <= 1'b1;
              r_state <= ST_HALT;
            end
          end
        end
        ST_DONE: begin
          r_valid <= 1'b0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_pc_valid) begin
            if (i_dnpc[1:0] == 2'b00) begin
              r_pc      <= i_dnpc;
              r_arvalid <= 1'b1;
              r_state   <= ST_AR;
            end else begin
              r_fault <= 1'b1;
              r_state <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_valid   <= 1'b0;
        end
        default: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
          r_valid   <= 1'b0;
          r_state   <= ST_HALT;
        end
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_mem_araddr  = r_pc;
  assign o_mem_arvalid = r_arvalid;
  assign o_mem_rready  = r_rready;
  assign o_inst        = r_inst;
  assign o_imm         = r_imm;
  assign o_valid       = r_valid;
  assign o_fault       = r_fault;

`ifdef YSYX_IFU_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = (r_state == ST_AR && !i_mem_arready) ||
                   (r_state == ST_R  && !i_mem_rvalid);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_fetch_cnt <= 32'h0;
      r_stall_cnt <= 32'h0;
    end else begin
      if (r_valid) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_fetch_cnt = 32'h0;
  assign o_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ysyx_24110006_ifu.sv
// tb/tb_ysyx_24110006_ifu.sv - self-checking bench for ysyx_24110006_ifu (YSYX_IFU_PERF_EN aware)
module tb_ysyx_24110006_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic [31:0] dnpc;
  logic [31:0] pc;
  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] imm;
  logic        valid;
  logic        fault;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  ysyx_24110006_ifu #(.RESET_PC(RST_PC)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_pc_valid    (pc_valid),
    .i_dnpc        (dnpc),
    .o_pc          (pc),
    .o_mem_arvalid (arvalid),
    .o_mem_araddr  (araddr),
    .i_mem_arready (arready),
    .i_mem_rvalid  (rvalid),
    .i_mem_rdata   (rdata),
    .i_mem_rresp   (rresp),
    .o_mem_rready  (rready),
    .o_inst        (inst),
    .o_imm         (imm),
    .o_valid       (valid),
    .o_fault       (fault),
    .o_fetch_cnt   (fetch_cnt),
    .o_stall_cnt   (stall_cnt)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] dnpc;
    logic [31:0] rdata;
    int          ar_dly;
    int          r_dly;
    logic [31:0] exp_imm;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  int n_pass  = 0;
  int n_total = 0;
  int exp_fetch = 0;
  int exp_stall = 0;
  int ar_cycles;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_counters(input string tag);
`ifdef YSYX_IFU_PERF_EN
    chk({tag, "_fetch_cnt"}, fetch_cnt, exp_fetch);
    chk({tag, "_stall_cnt"}, stall_cnt, exp_stall);
`else
    chk({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
    chk({tag, "_stall_cnt"}, stall_cnt, 32'h0);
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc"}, pc, RST_PC);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_imm"}, imm, 32'h0);
    chk({tag, "_ctrl"}, {28'h0, valid, arvalid, rready, fault}, 32'h0);
    chk({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
    chk({tag, "_stall_cnt"}, stall_cnt, 32'h0);
  endtask

  // Memory responder: entered at a negedge just before the edge that leaves IDLE/WAIT.
  // Returns the number of rising edges until o_valid (or o_fault) is observed.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input logic [1:0] resp,
                          input int ar_dly, input int r_dly, input logic [31:0] exp_imm,
                          output int lat);
    int   ar_seen = 0;
    int   r_seen  = 0;
    logic done    = 1'b0;
    logic addr_ok = 1'b1;
    exp_t e;
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      pc_valid = 1'b0;
      if (valid) begin
        done = 1'b1;
        if (sb.size() == 0) chk("sb_underflow", 32'h1, 32'h0);
        else begin
          e = sb.pop_front();
          chk("sb_inst", inst, e.inst);
          chk("sb_imm", imm, e.imm);
          chk("sb_pc", pc, e.pc);
        end
      end
      if (fault) done = 1'b1;
      if (arvalid) begin
        if (araddr !== addr) addr_ok = 1'b0;
        ar_seen++;
        arready = (ar_seen > ar_dly);
      end else arready = 1'b0;
      if (rready) begin
        r_seen++;
        if (r_seen > r_dly) begin
          rvalid = 1'b1;
          rdata  = word;
          rresp  = resp;
          if (resp == 2'b00) sb.push_back('{inst: word, imm: exp_imm, pc: addr});
        end else begin
          rvalid = 1'b0;
          rdata  = $urandom;
          rresp  = 2'(r_seen);
        end
      end else rvalid = 1'b0;
    end
    arready = 1'b0;
    rvalid  = 1'b0;
    ar_cycles = ar_seen;
    chk("fetch_done", {31'h0, done}, 32'h1);
    chk("araddr_stable", {31'h0, addr_ok}, 32'h1);
  endtask

  initial begin
    int lat;
    int bad;

    vecs[0] = '{32'h8000_0010, 32'h3020_0073, 0, 0, 32'h0000_0302};
    vecs[1] = '{32'h8000_0014, 32'hFE00_0EE3, 3, 2, 32'hFFFF_FFFC};
    vecs[2] = '{32'h8000_0018, 32'h1234_5537, 1, 0, 32'h1234_5000};
    vecs[3] = '{32'h8000_001C, 32'h0080_006F, 0, 1, 32'h0000_0008};
    vecs[4] = '{32'h8000_0020, 32'hFE11_2E23, 2, 0, 32'hFFFF_FFFC};
    vecs[5] = '{32'h8000_0024, 32'h4031_00B3, 0, 0, 32'h0000_0020};
    vecs[6] = '{32'h8000_0028, 32'hFFFF_F00F, 0, 3, 32'h0000_0000};
    vecs[7] = '{32'h8000_002C, 32'h0000_0073, 1, 1, 32'h0000_0000};
    vecs[8] = '{32'h8000_0030, 32'hFFF0_0093, 0, 0, 32'hFFFF_FFFF};
    vecs[9] = '{32'h8000_0034, 32'hFFFF_F097, 0, 0, 32'hFFFF_F000};

    rst = 1'b1; pc_valid = 1'b0; dnpc = 32'h0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");

    // Zero-wait fetch straight out of reset.
    rst = 1'b0;
    do_fetch(RST_PC, 32'h0050_0093, 2'b00, 0, 0, 32'h5, lat);
    exp_fetch++;
    chk("zw_latency", lat, 3);
    chk("zw_ar_cycles", ar_cycles, 1);
    @(negedge clk);
    chk("valid_pulse_one_cycle", {31'h0, valid}, 32'h0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (arvalid || rready || valid) bad++;
      @(negedge clk);
    end
    chk("wait_idle_quiet", bad, 0);
    chk("hold_inst", inst, 32'h0050_0093);
    chk_counters("after_first");

    foreach (vecs[k]) begin
      pc_valid = 1'b1;
      dnpc     = vecs[k].dnpc;
      do_fetch(vecs[k].dnpc, vecs[k].rdata, 2'b00, vecs[k].ar_dly, vecs[k].r_dly, vecs[k].exp_imm, lat);
      exp_fetch++;
      exp_stall += vecs[k].ar_dly + vecs[k].r_dly;
      chk($sformatf("vec%0d_latency", k), lat, 3 + vecs[k].ar_dly + vecs[k].r_dly);
      chk($sformatf("vec%0d_ar_cycles", k), ar_cycles, vecs[k].ar_dly + 1);
      chk($sformatf("vec%0d_pc", k), pc, vecs[k].dnpc);
      @(negedge clk);
    end
    chk_counters("after_vecs");

    // Bus error response halts the fetch.
    pc_valid = 1'b1;
    dnpc     = 32'h8000_0100;
    do_fetch(32'h8000_0100, 32'h0050_0093, 2'b10, 0, 0, 32'h0, lat);
    chk("rresp_fault", {31'h0, fault}, 32'h1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      pc_valid = 1'b1;
      dnpc     = 32'h8000_0200;
      @(negedge clk);
      if (arvalid || rready || valid || !fault) bad++;
    end
    pc_valid = 1'b0;
    chk("halt_quiet_20", bad, 0);
    chk("sb_empty_fault", sb.size(), 0);

    // Misaligned next PC.
    rst = 1'b1;
    #1;
    chk("fault_cleared", {31'h0, fault}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_fetch = 0;
    exp_stall = 0;
    do_fetch(RST_PC, 32'h0050_0093, 2'b00, 0, 0, 32'h5, lat);
    @(negedge clk);
    pc_valid = 1'b1;
    dnpc     = 32'h8000_0002;
    @(negedge clk);
    pc_valid = 1'b0;
    chk("misalign_fault", {31'h0, fault}, 32'h1);
    chk("misalign_no_ar", {31'h0, arvalid}, 32'h0);
    chk("misalign_pc_kept", pc, RST_PC);

    // Reset while waiting for read data.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_fetch(RST_PC, 32'h0050_0093, 2'b00, 0, 0, 32'h5, lat);
    @(negedge clk);
    pc_valid = 1'b1;
    dnpc     = 32'h8000_0040;
    @(negedge clk);
    pc_valid = 1'b0;
    chk("r_test_pc", pc, 32'h8000_0040);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("in_r_state", {30'h0, arvalid, rready}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("reset_in_r");
    @(negedge clk);
    rst = 1'b0;
    do_fetch(RST_PC, 32'h1234_5537, 2'b00, 0, 0, 32'h1234_5000, lat);
    chk("restart_latency", lat, 3);
    chk("restart_pc", pc, RST_PC);
    chk("sb_empty_end", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_24110006_ifu.md
# ysyx_24110006_ifu

Instruction fetch unit of the multi-cycle core. Holds the PC, fetches one 32-bit instruction per retirement over an AXI-lite-style read channel, generates the sign-extended immediate, and delivers instruction plus immediate to the decode stage with a one-cycle valid pulse. The decode stage captures on that pulse and re-arms afterwards. The next fetch starts only when writeback returns the next PC.

## Interface
- RESET_PC, default 32'h8000_0000: first fetch address after reset.
- i_clock  in  1  core clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_pc_valid  in  1  writeback done; i_dnpc valid this cycle.
- i_dnpc  in  32  next PC from writeback.
- o_pc  out  32  PC of the instruction being fetched or delivered.
- o_mem_arvalid  out  1  read address valid.
- o_mem_araddr  out  32  equals o_pc.
- i_mem_arready  in  1  read address accepted.
- i_mem_rvalid  in  1  read data valid.
- i_mem_rdata  in  32  instruction word.
- i_mem_rresp  in  2  00 = OKAY; any other value = error.
- o_mem_rready  out  1  read data accept.
- o_inst  out  32  fetched instruction, registered.
- o_imm  out  32  immediate of o_inst, registered.
- o_valid  out  1  one-cycle pulse; o_inst/o_imm valid.
- o_fault  out  1  sticky fetch fault.
- o_fetch_cnt  out  32  performance counter; see Configuration.
- o_stall_cnt  out  32  performance counter; see Configuration.

## Operation
- States: IDLE, AR, R, DONE, WAIT, HALT. Reset state is IDLE.
- IDLE → AR unconditionally after one cycle.
- AR: o_mem_arvalid=1. When i_mem_arready=1 → R.
- R: o_mem_rready=1. When i_mem_rvalid=1:
  - rresp==00: register o_inst ← rdata and o_imm ← immgen(rdata); go to DONE.
  - otherwise: o_fault ← 1; go to HALT.
- DONE: o_valid=1 for exactly this cycle; then → WAIT.
- WAIT: i_pc_valid is sampled only here; it is ignored in every other state. When i_pc_valid=1:
  - i_dnpc[1:0]==00: o_pc ← i_dnpc; go to AR.
  - otherwise: o_fault ← 1; go to HALT.
- HALT: all handshake outputs stay 0 until reset.
- Immediate encoding by opcode inst[6:0]:
  - I-type (0010011, 1100111, 0000011, 1110011): {{20{i[31]}}, i[31:20]}.
  - U-type (0110111, 0010111): {i[31:12], 12'b0}.
  - J-type (1101111): {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}.
  - S-type (0100011): {{20{i[31]}}, i[31:25], i[11:7]}.
  - B-type (1100011): {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}.
  - R-type (0110011): {25'b0, i[31:25]}.
  - Any other opcode: 0.
- Decode depends on the immediate: mret gives imm=0x302 (imm[1]=1); ecall gives imm=0.

## Timing
- Reset values:
  - o_pc = RESET_PC.
  - o_inst = 0, o_imm = 0.
  - o_valid, o_mem_arvalid, o_mem_rready, o_fault = 0.
  - Counters = 0.
- Asserting reset in any state returns to IDLE immediately. Any outstanding bus transaction is abandoned.
- o_mem_arvalid and o_mem_rready are decoded from state only. They have no dependency on inputs in the same cycle.
- Zero-wait memory: reset released at edge 0 → AR in cycle 1, R in cycle 2, o_valid in cycle 3.
- Each wait cycle on arready or rvalid adds one cycle of latency.
- arready=1 in the first AR cycle → R on the next cycle. rvalid=1 in the first R cycle → DONE on the next cycle.
- o_mem_araddr is stable while arvalid=1.
- o_inst and o_imm hold their values until the next successful R capture.
- Minimum spacing between o_valid pulses is 4 cycles (DONE, WAIT, AR, R).

## Configuration
- YSYX_IFU_PERF_EN defined:
  - o_fetch_cnt increments on every o_valid pulse.
  - o_stall_cnt increments on every cycle spent in AR or R with the handshake not completing.
  - Both counters wrap at 2^32 and clear on reset.
- YSYX_IFU_PERF_EN undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Package ysyx_24110006_pkg holds:
  - opcode localparams;
  - the state enum;
  - the RESP_OKAY constant;
  - the RESET_PC default.
- One sub-module, ysyx_24110006_immgen: purely combinational, inst[31:0] → imm[31:0].
- The FSM, PC register and optional counters live in the top module.

## Test plan
- Zero-wait memory, rdata=0x00500093 (addi x1,x0,5), rresp=00:
  - araddr=0x8000_0000;
  - o_valid high in cycle 3 only;
  - o_inst=0x00500093, o_imm=5.
- arready delayed 3 cycles, rvalid delayed 2 cycles:
  - arvalid held 4 cycles with a stable address;
  - o_valid 5 cycles later than the zero-wait case;
  - with PERF: o_stall_cnt=5.
- After delivery, i_pc_valid=1 with i_dnpc=0x8000_0010 → next araddr=0x8000_0010, o_pc=0x8000_0010.
- Immediate coverage:
  - rdata=0x30200073 (mret) → o_imm=0x302;
  - rdata=0xFE000EE3 (beq x0,x0,-4) → o_imm=0xFFFF_FFFC;
  - rdata=0x12345537 (lui) → o_imm=0x1234_5000.
- Fault cases:
  - rresp=10 → no o_valid, o_fault=1, arvalid stays 0 for 20 cycles;
  - i_dnpc=0x8000_0002 → o_fault=1.
- Reset asserted while in R → all outputs return to reset values immediately; the fetch restarts at RESET_PC after release.
